// File: rtl/word64_fifo_ctrl.sv
// Purpose: FIFO controller for the dual-port 64x128 local buffer; port A writes, port B prefetches into a 2-entry skid.
// Latency: push in cycle 0 -> read issue cycle 1 -> DOB cycle 2 -> pop_valid cycle 3 (from empty); 1 entry/cycle sustained.
// Backpressure: push_ready drops when 64 unread entries sit in SRAM; reads stall while the skid buffer has no free slot.
module word64_fifo_ctrl #(
    parameter int AW = 6,
    parameter int DW = 128,
    parameter int NL = 8
) (
    input  logic          CK,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push_valid,
    output logic          push_ready,
    input  logic [DW-1:0] push_data,
    input  logic [NL-1:0] push_lane,
    output logic          pop_valid,
    input  logic          pop_ready,
    output logic [DW-1:0] pop_data,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic [AW-1:0] sram_A,
    output logic [NL-1:0] sram_WEAN,
    output logic          sram_OEA,
    output logic [DW-1:0] sram_DIA,
    output logic [AW-1:0] sram_B,
    output logic [NL-1:0] sram_WEBN,
    output logic          sram_OEB,
    output logic [DW-1:0] sram_DIB,
    input  logic [DW-1:0] sram_DOB
);

    // SRAM capacity expressed in the occupancy counter width
    localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   sram_cnt;
    logic          rd_pend;
    logic [1:0]    ob_cnt;
    logic [DW-1:0] ob0;
    logic [DW-1:0] ob1;
    logic          live;

    logic          push_fire;
    logic          pop_fire;
    logic          rd_go;
    logic [2:0]    ob_occ;

    // live gates the write port so nothing reaches the SRAM while reset is held
    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    // Handshakes and read-issue decision; skid slots already promised (held + in flight) must stay below 2
    always_comb begin
        push_ready = live && !flush && (sram_cnt < DEPTH_C);
        push_fire  = push_valid && push_ready;
        pop_valid  = (ob_cnt != 2'd0);
        pop_fire   = pop_valid && pop_ready;
        ob_occ     = {1'b0, ob_cnt} + {2'b00, rd_pend} - {2'b00, pop_fire};
        rd_go      = (sram_cnt != '0) && (ob_occ < 3'd2) && !flush;
    end

    // Static SRAM port drive: A is write-only, B is read-only
    always_comb begin
        sram_A    = wr_ptr;
        sram_OEA  = 1'b0;
        sram_DIA  = push_data;
        sram_WEAN = push_fire ? ~push_lane : {NL{1'b1}};
        sram_B    = rd_ptr;
        sram_OEB  = rd_go;
        sram_WEBN = {NL{1'b1}};
        sram_DIB  = '0;
    end

    // Pointers and SRAM occupancy; pointers wrap naturally at 2**AW
    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sram_cnt <= '0;
            rd_pend  <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sram_cnt <= '0;
            rd_pend  <= 1'b0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_go) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_fire, rd_go})
                2'b10:   sram_cnt <= sram_cnt + 1'b1;
                2'b01:   sram_cnt <= sram_cnt - 1'b1;
                default: sram_cnt <= sram_cnt;
            endcase
            rd_pend <= rd_go;
        end
    end

    // Two-entry output skid buffer; ob0 is the registered head, DOB lands the cycle after issue
    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            ob_cnt <= 2'd0;
            ob0    <= '0;
            ob1    <= '0;
        end else if (flush) begin
            ob_cnt <= 2'd0;
            ob0    <= '0;
            ob1    <= '0;
        end else begin
            case ({rd_pend, pop_fire})
                2'b10: begin
                    if (ob_cnt == 2'd0) begin
                        ob0 <= sram_DOB;
                    end else begin
                        ob1 <= sram_DOB;
                    end
                    ob_cnt <= ob_cnt + 2'd1;
                end
                2'b01: begin
                    ob0    <= ob1;
                    ob1    <= '0;
                    ob_cnt <= ob_cnt - 2'd1;
                end
                2'b11: begin
                    if (ob_cnt == 2'd1) begin
                        ob0 <= sram_DOB;
                    end else begin
                        ob0 <= ob1;
                        ob1 <= sram_DOB;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status: everything owned by the controller, including the read in flight
    always_comb begin
        pop_data = ob0;
        count    = sram_cnt + {{AW{1'b0}}, rd_pend} + {{(AW-1){1'b0}}, ob_cnt};
        empty    = (count == '0);
        full     = (sram_cnt == DEPTH_C);
    end

endmodule

// File: tb/tb_word64_fifo_ctrl.sv
module tb_word64_fifo_ctrl;

    logic         CK = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         push_valid;
    logic         push_ready;
    logic [127:0] push_data;
    logic [7:0]   push_lane;
    logic         pop_valid;
    logic         pop_ready;
    logic [127:0] pop_data;
    logic [6:0]   count;
    logic         empty;
    logic         full;
    logic [5:0]   sram_A;
    logic [7:0]   sram_WEAN;
    logic         sram_OEA;
    logic [127:0] sram_DIA;
    logic [5:0]   sram_B;
    logic [7:0]   sram_WEBN;
    logic         sram_OEB;
    logic [127:0] sram_DIB;
    logic [127:0] sram_DOB = '0;

    always #5 CK = ~CK;

    word64_fifo_ctrl dut (
        .CK(CK), .rst_n(rst_n), .flush(flush),
        .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data), .push_lane(push_lane),
        .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
        .count(count), .empty(empty), .full(full),
        .sram_A(sram_A), .sram_WEAN(sram_WEAN), .sram_OEA(sram_OEA), .sram_DIA(sram_DIA),
        .sram_B(sram_B), .sram_WEBN(sram_WEBN), .sram_OEB(sram_OEB), .sram_DIB(sram_DIB),
        .sram_DOB(sram_DOB)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int coll    = 0;

    // Behavioural SRAM: controls latched on the falling edge, acted on at the rising edge
    logic [127:0] mem [64];
    logic         l_oeb  = 1'b0;
    logic [5:0]   l_a    = '0;
    logic [5:0]   l_b    = '0;
    logic [7:0]   l_wean = 8'hFF;
    logic [127:0] l_dia  = '0;

    always @(negedge CK) begin
        l_oeb  = sram_OEB;
        l_a    = sram_A;
        l_b    = sram_B;
        l_wean = sram_WEAN;
        l_dia  = sram_DIA;
        if (rst_n && sram_OEB && (sram_WEAN != 8'hFF) && (sram_A == sram_B)) coll++;
    end

    always @(posedge CK) begin
        if (l_oeb) sram_DOB <= mem[l_b];
        for (int l = 0; l < 8; l++)
            if (!l_wean[l]) mem[l_a][16*l +: 16] <= l_dia[16*l +: 16];
    end

    // Scoreboard: shadow of SRAM contents so partial-lane writes have a known expected value
    logic [127:0] sbq [$];
    logic [127:0] shadow [64];
    int           wp = 0;

    logic         s_pushed, s_popped, s_pv, s_pr, s_empty, s_full, s_oeb;
    logic [7:0]   s_wean;
    logic [5:0]   s_a, s_b;
    logic [6:0]   s_cnt;
    logic [127:0] s_pdat;
    logic [127:0] exp_v;

    // Drive one cycle (called at posedge+1), sample at the falling edge, record accepted pushes
    task automatic step(input logic pv, input logic [127:0] pd, input logic [7:0] pl,
                        input logic pr, input logic fl);
        push_valid = pv; push_data = pd; push_lane = pl; pop_ready = pr; flush = fl;
        @(negedge CK);
        s_pushed = push_valid && push_ready;
        s_popped = pop_valid && pop_ready;
        s_pv = pop_valid; s_pr = push_ready; s_empty = empty; s_full = full;
        s_oeb = sram_OEB; s_wean = sram_WEAN; s_a = sram_A; s_b = sram_B;
        s_cnt = count; s_pdat = pop_data;
        if (fl) begin sbq.delete(); wp = 0; end
        if (s_pushed) begin
            for (int l = 0; l < 8; l++)
                if (pl[l]) shadow[wp][16*l +: 16] = pd[16*l +: 16];
            sbq.push_back(shadow[wp]);
            wp = (wp + 1) % 64;
        end
        @(posedge CK); #1;
    endtask

    task automatic test_reset();
        #12;
        n_tests++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pop_valid got %b want 0", pop_valid); end
        n_tests++; if (pop_data !== 128'h0) begin n_fail++; $display("FAIL rst_pop_data got %h want 0", pop_data); end
        n_tests++; if (count !== 7'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", count); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b want 1", empty); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b want 0", full); end
        n_tests++; if (sram_WEAN !== 8'hFF) begin n_fail++; $display("FAIL rst_wean got %h want ff", sram_WEAN); end
        n_tests++; if (sram_OEB !== 1'b0) begin n_fail++; $display("FAIL rst_oeb got %b want 0", sram_OEB); end
        push_valid = 1'b0;
        @(negedge CK); rst_n = 1'b1;
        @(posedge CK); #1;
        n_tests++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL rst_push_ready got %b want 1", push_ready); end
    endtask

    task automatic test_single();
        step(1'b1, 128'h1, 8'hFF, 1'b1, 1'b0);
        n_tests++; if (s_wean !== 8'h00 || s_a !== 6'd0) begin n_fail++; $display("FAIL single_write wean=%h a=%0d want 00/0", s_wean, s_a); end
        step(1'b0, '0, 8'hFF, 1'b1, 1'b0);
        n_tests++; if (s_oeb !== 1'b1 || s_b !== 6'd0) begin n_fail++; $display("FAIL single_read oeb=%b b=%0d want 1/0", s_oeb, s_b); end
        step(1'b0, '0, 8'hFF, 1'b1, 1'b0);
        n_tests++; if (s_pv !== 1'b0) begin n_fail++; $display("FAIL single_early pop_valid=%b want 0", s_pv); end
        step(1'b0, '0, 8'hFF, 1'b1, 1'b0);
        n_tests++;
        if (!s_popped || sbq.size() == 0) begin n_fail++; $display("FAIL single_pop popped=%b want 1 in cycle 3", s_popped); end
        else begin exp_v = sbq.pop_front(); if (s_pdat !== exp_v) begin n_fail++; $display("FAIL single_data got %h want %h", s_pdat, exp_v); end end
        step(1'b0, '0, 8'hFF, 1'b1, 1'b0);
        n_tests++; if (s_empty !== 1'b1) begin n_fail++; $display("FAIL single_empty got %b want 1", s_empty); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int npop = 0;
        for (int i = 0; i < 70; i++) begin
            step(1'b1, 128'(1000 + i), 8'hFF, 1'b0, 1'b0);
            if (s_pushed) acc++;
        end
        n_tests++; if (acc != 66) begin n_fail++; $display("FAIL bp_accepts got %0d want 66", acc); end
        step(1'b0, '0, 8'hFF, 1'b0, 1'b0);
        n_tests++; if (s_cnt !== 7'd66) begin n_fail++; $display("FAIL bp_count got %0d want 66", s_cnt); end
        n_tests++; if (s_full !== 1'b1 || s_pr !== 1'b0) begin n_fail++; $display("FAIL bp_full full=%b push_ready=%b want 1/0", s_full, s_pr); end
        for (int i = 0; i < 80; i++) begin
            step(1'b0, '0, 8'hFF, 1'b1, 1'b0);
            if (s_popped) begin
                npop++; n_tests++;
                if (sbq.size() == 0) begin n_fail++; $display("FAIL bp_extra_pop got %h want none", s_pdat); end
                else begin exp_v = sbq.pop_front(); if (s_pdat !== exp_v) begin n_fail++; $display("FAIL bp_order got %h want %h", s_pdat, exp_v); end end
            end
        end
        n_tests++; if (npop != 66 || s_empty !== 1'b1) begin n_fail++; $display("FAIL bp_drain pops=%0d empty=%b want 66/1", npop, s_empty); end
    endtask

    task automatic test_back_to_back();
        int pushed = 0;
        int npop = 0;
        int first = -1;
        int last = -1;
        int bad = 0;
        coll = 0;
        for (int cyc = 0; cyc < 240; cyc++) begin
            step(pushed < 200, {32'hA5A5_0000 + 32'(pushed), 96'(pushed * 3)}, 8'hFF, 1'b1, 1'b0);
            if (s_pushed) pushed++;
            if (s_popped) begin
                if (first < 0) first = cyc;
                last = cyc; npop++;
                if (sbq.size() == 0) bad++;
                else begin exp_v = sbq.pop_front(); if (s_pdat !== exp_v) bad++; end
            end
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL b2b_data bad=%0d want 0", bad); end
        n_tests++; if (npop != 200 || pushed != 200) begin n_fail++; $display("FAIL b2b_count pops=%0d pushes=%0d want 200/200", npop, pushed); end
        n_tests++; if (first != 3 || last != 202) begin n_fail++; $display("FAIL b2b_rate first=%0d last=%0d want 3/202", first, last); end
        n_tests++; if (coll != 0) begin n_fail++; $display("FAIL b2b_collision got %0d want 0", coll); end
    endtask

    task automatic test_lanes();
        logic seen = 1'b0;
        step(1'b0, '0, 8'hFF, 1'b0, 1'b1);
        step(1'b1, {128{1'b1}}, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 8'hFF, 1'b1, 1'b0);
            if (s_popped && sbq.size() != 0) begin
                exp_v = sbq.pop_front(); seen = 1'b1;
                n_tests++; if (s_pdat !== exp_v) begin n_fail++; $display("FAIL lanes_prefill got %h want %h", s_pdat, exp_v); end
            end
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL lanes_prefill_timeout popped=0 want 1"); end
        step(1'b0, '0, 8'hFF, 1'b0, 1'b1);
        step(1'b1, 128'h0, 8'h0F, 1'b1, 1'b0);
        n_tests++; if (s_wean !== 8'hF0) begin n_fail++; $display("FAIL lanes_wean got %h want f0", s_wean); end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 8'hFF, 1'b1, 1'b0);
            if (s_popped && sbq.size() != 0) begin
                exp_v = sbq.pop_front(); seen = 1'b1;
                n_tests++; if (s_pdat !== {64'hFFFF_FFFF_FFFF_FFFF, 64'h0} || s_pdat !== exp_v) begin
                    n_fail++; $display("FAIL lanes_merge got %h want %h", s_pdat, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}); end
            end
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL lanes_timeout popped=0 want 1"); end
    endtask

    task automatic test_flush();
        int at = -1;
        for (int i = 0; i < 10; i++) step(1'b1, 128'(700 + i), 8'hFF, 1'b0, 1'b0);
        step(1'b1, 128'd710, 8'hFF, 1'b1, 1'b0);
        n_tests++;
        if (!s_popped || sbq.size() == 0) begin n_fail++; $display("FAIL flush_prepop popped=%b want 1", s_popped); end
        else begin exp_v = sbq.pop_front(); if (s_pdat !== exp_v) begin n_fail++; $display("FAIL flush_prepop_data got %h want %h", s_pdat, exp_v); end end
        n_tests++; if (s_oeb !== 1'b1) begin n_fail++; $display("FAIL flush_rdpend oeb=%b want 1", s_oeb); end
        step(1'b1, 128'd999, 8'hFF, 1'b0, 1'b1);
        n_tests++; if (s_cnt !== 7'd10) begin n_fail++; $display("FAIL flush_held got %0d want 10", s_cnt); end
        n_tests++; if (s_pr !== 1'b0 || s_wean !== 8'hFF || s_oeb !== 1'b0) begin
            n_fail++; $display("FAIL flush_override push_ready=%b wean=%h oeb=%b want 0/ff/0", s_pr, s_wean, s_oeb); end
        step(1'b0, '0, 8'hFF, 1'b0, 1'b0);
        n_tests++; if (s_cnt !== 7'd0 || s_empty !== 1'b1 || s_pv !== 1'b0) begin
            n_fail++; $display("FAIL flush_clear count=%0d empty=%b pop_valid=%b want 0/1/0", s_cnt, s_empty, s_pv); end
        for (int c = 0; c < 8; c++) begin
            step(c == 0, 128'h1234_5678, 8'hFF, 1'b1, 1'b0);
            if (s_popped) begin
                at = c;
                n_tests++;
                if (sbq.size() == 0) begin n_fail++; $display("FAIL flush_stale_pop got %h want none", s_pdat); end
                else begin exp_v = sbq.pop_front(); if (s_pdat !== exp_v || exp_v !== 128'h1234_5678) begin
                    n_fail++; $display("FAIL flush_after_data got %h want %h", s_pdat, 128'h1234_5678); end end
            end
        end
        n_tests++; if (at != 3) begin n_fail++; $display("FAIL flush_after_latency got %0d want 3", at); end
    endtask

    task automatic test_reset_mid();
        int npop = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 128'(300 + i), 8'hFF, 1'b1, 1'b0);
            if (s_popped && sbq.size() != 0) begin
                exp_v = sbq.pop_front();
                n_tests++; if (s_pdat !== exp_v) begin n_fail++; $display("FAIL rmid_pre got %h want %h", s_pdat, exp_v); end
            end
        end
        push_valid = 1'b1; push_lane = 8'hFF;
        rst_n = 1'b0;
        #1;
        n_tests++; if (pop_valid !== 1'b0 || count !== 7'd0 || empty !== 1'b1 || full !== 1'b0) begin
            n_fail++; $display("FAIL rmid_status pop_valid=%b count=%0d empty=%b full=%b want 0/0/1/0", pop_valid, count, empty, full); end
        n_tests++; if (sram_WEAN !== 8'hFF || sram_OEB !== 1'b0 || pop_data !== 128'h0) begin
            n_fail++; $display("FAIL rmid_ports wean=%h oeb=%b pop_data=%h want ff/0/0", sram_WEAN, sram_OEB, pop_data); end
        #4;
        rst_n = 1'b1;
        push_valid = 1'b0;
        sbq.delete(); wp = 0;
        @(posedge CK); #1;
        for (int i = 0; i < 12; i++) begin
            step(i < 4, 128'(400 + i), 8'hFF, 1'b1, 1'b0);
            if (s_popped) begin
                npop++; n_tests++;
                if (sbq.size() == 0) begin n_fail++; $display("FAIL rmid_extra got %h want none", s_pdat); end
                else begin exp_v = sbq.pop_front(); if (s_pdat !== exp_v) begin n_fail++; $display("FAIL rmid_post got %h want %h", s_pdat, exp_v); end end
            end
        end
        n_tests++; if (npop != 4 || s_empty !== 1'b1) begin n_fail++; $display("FAIL rmid_resume pops=%0d empty=%b want 4/1", npop, s_empty); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin mem[i] = '0; shadow[i] = '0; end
        rst_n = 1'b0; flush = 1'b0; pop_ready = 1'b0;
        push_valid = 1'b1; push_data = {128{1'b1}}; push_lane = 8'hFF;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_lanes();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
